ram_bist_ctrl: RTL and testbench



---
 rtl/ram_bist_ctrl.sv | 173 +++++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist_ctrl.sv
// Fill-and-verify sequencer for the 8x64K synchronous RAM: writes a pattern over an
// inclusive (possibly wrapping) address range, reads it back and records mismatches.
module ram_bist_ctrl #(
  parameter int ROW_SHIFT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [1:0]  op,
  input  logic [1:0]  mode,
  input  logic [7:0]  pat_val,
  input  logic [15:0] start_addr,
  input  logic [15:0] end_addr,
  output logic        ram_we,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] first_err_addr,
  output logic [7:0]  first_err_data
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FILL   = 3'd1;
  localparam logic [2:0] S_VERIFY = 3'd2;
  localparam logic [2:0] S_LAST   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]  state;
  logic [15:0] cur;
  logic [15:0] last_addr;
  logic        verify_after_fill;
  logic [1:0]  mode_q;
  logic [7:0]  pat_q;
  logic [15:0] start_q;
  logic [15:0] end_q;
  logic [7:0]  exp_q;
  logic [15:0] addr_q;
  logic        rd_valid_q;

  logic [7:0]  cur_pat;
  logic        cmp_en;
  logic        mismatch;
  logic [15:0] err_next;

  always_comb begin
    cur_pat = 8'h00;
    case (mode_q)
      2'd0:    cur_pat = pat_q;
      2'd1:    cur_pat = cur[7:0];
      2'd2:    cur_pat = {7'b0, cur[ROW_SHIFT]};
      default: cur_pat = (cur[0] ^ cur[ROW_SHIFT]) ? 8'hAA : 8'h55;
    endcase
  end

  // Read data lags its address by one cycle, so the first VERIFY cycle has nothing to compare.
  always_comb begin
    cmp_en   = ((state == S_VERIFY) && rd_valid_q) || (state == S_LAST);
    mismatch = cmp_en && (ram_dout != exp_q);
    err_next = err_count;
    if (mismatch && (err_count != 16'hFFFF))
      err_next = err_count + 16'd1;
  end

  always_comb begin
    busy     = (state == S_FILL) || (state == S_VERIFY) || (state == S_LAST);
    done     = (state == S_DONE);
    ram_we   = (state == S_FILL);
    ram_addr = ((state == S_FILL) || (state == S_VERIFY)) ? cur : last_addr;
    ram_din  = cur_pat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= S_IDLE;
      cur               <= 16'h0000;
      last_addr         <= 16'h0000;
      verify_after_fill <= 1'b0;
      mode_q            <= 2'd0;
      pat_q             <= 8'h00;
      start_q           <= 16'h0000;
      end_q             <= 16'h0000;
      exp_q             <= 8'h00;
      addr_q            <= 16'h0000;
      rd_valid_q        <= 1'b0;
      pass              <= 1'b0;
      err_count         <= 16'h0000;
      first_err_addr    <= 16'h0000;
      first_err_data    <= 8'h00;
    end else begin
      rd_valid_q <= (state == S_VERIFY);
      if (cmp_en && !abort) begin
        err_count <= err_next;
        if (mismatch && (err_count == 16'h0000)) begin
          first_err_addr <= addr_q;
          first_err_data <= ram_dout;
        end
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            verify_after_fill <= op[1];
            mode_q            <= mode;
            pat_q             <= pat_val;
            start_q           <= start_addr;
            end_q             <= end_addr;
            cur               <= start_addr;
            err_count         <= 16'h0000;
            first_err_addr    <= 16'h0000;
            first_err_data    <= 8'h00;
            pass              <= 1'b0;
            case (op)
              2'b00: begin
                state <= S_DONE;
                pass  <= 1'b1;
              end
              2'b10:   state <= S_VERIFY;
              default: state <= S_FILL;
            endcase
          end
        end
        S_FILL: begin
          if (abort) begin
            state <= S_IDLE;
            pass  <= 1'b0;
          end else begin
            last_addr <= cur;
            if (cur == end_q) begin
              cur <= start_q;
              if (verify_after_fill) begin
                state <= S_VERIFY;
              end else begin
                state <= S_DONE;
                pass  <= 1'b1;
              end
            end else begin
              cur <= cur + 16'd1;
            end
          end
        end
        S_VERIFY: begin
          if (abort) begin
            state <= S_IDLE;
            pass  <= 1'b0;
          end else begin
            last_addr <= cur;
            exp_q     <= cur_pat;
            addr_q    <= cur;
            if (cur == end_q)
              state <= S_LAST;
            else
              cur <= cur + 16'd1;
          end
        end
        S_LAST: begin
          if (abort) begin
            state <= S_IDLE;
            pass  <= 1'b0;
          end else begin
            state <= S_DONE;
            pass  <= (err_next == 16'h0000);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Scoreboard bench for ram_bist_ctrl: directed runs push expected completion records,
// a forked monitor pops and compares them whenever done pulses.
module tb_ram_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [1:0]  op;
  logic [1:0]  mode;
  logic [7:0]  pat_val;
  logic [15:0] start_addr;
  logic [15:0] end_addr;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_count;
  logic [15:0] first_err_addr;
  logic [7:0]  first_err_data;

  typedef struct {
    logic        pass;
    logic [15:0] err;
    logic [15:0] faddr;
    logic [7:0]  fdata;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int unsigned we_total = 0;

  logic [7:0]  mem [0:65535];
  logic        poke_en = 1'b0;
  logic [15:0] poke_addr = 16'h0000;
  logic [7:0]  poke_data = 8'h00;

  ram_bist_ctrl #(.ROW_SHIFT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .op(op), .mode(mode),
    .pat_val(pat_val), .start_addr(start_addr), .end_addr(end_addr),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .first_err_data(first_err_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model with registered read; the poke port stands in for direct RAM access.
  always @(posedge clk) begin
    if (poke_en)
      mem[poke_addr] <= poke_data;
    else if (ram_we)
      mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  always @(negedge clk) if (ram_we === 1'b1) we_total <= we_total + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          check_output("done_cycle", cyc, e.cyc);
          check_output("pass", {31'b0, pass}, {31'b0, e.pass});
          check_output("err_count", {16'b0, err_count}, {16'b0, e.err});
          check_output("first_err_addr", {16'b0, first_err_addr}, {16'b0, e.faddr});
          check_output("first_err_data", {24'b0, first_err_data}, {24'b0, e.fdata});
        end
      end
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] o, input logic [1:0] m, input logic [7:0] pv,
                                input logic [15:0] sa, input logic [15:0] ea,
                                input logic e_pass, input logic [15:0] e_err,
                                input logic [15:0] e_faddr, input logic [7:0] e_fdata,
                                input int unsigned lat, input bit glitch);
    exp_t e;
    bit   seen;
    e.pass  = e_pass;
    e.err   = e_err;
    e.faddr = e_faddr;
    e.fdata = e_fdata;
    e.cyc   = cyc + lat;
    exp_q.push_back(e);
    op = o; mode = m; pat_val = pv; start_addr = sa; end_addr = ea;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (glitch) begin
      @(posedge clk); #1;
      op = 2'b10; mode = 2'd0; pat_val = 8'h33; start_addr = 16'h0000; end_addr = 16'h0000;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < int'(lat) + 8 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got no done expected done at cycle %0d", e.cyc);
      exp_q.delete();
    end
    @(posedge clk); #1;
    check_output("done_one_cycle", {31'b0, done}, 32'd0);
  endtask

  initial begin
    int unsigned we0;
    fork
      monitor_loop();
    join_none
    rst = 1'b1; start = 1'b0; abort = 1'b0; op = 2'b00; mode = 2'd0; pat_val = 8'h00;
    start_addr = 16'h0000; end_addr = 16'h0000;
    repeat (2) @(negedge clk);
    check_output("rst_ram_we", {31'b0, ram_we}, 32'd0);
    check_output("rst_ram_addr", {16'b0, ram_addr}, 32'd0);
    check_output("rst_ram_din", {24'b0, ram_din}, 32'd0);
    check_output("rst_busy", {31'b0, busy}, 32'd0);
    check_output("rst_pass", {31'b0, pass}, 32'd0);
    check_output("rst_err_count", {16'b0, err_count}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Row parity fill+verify over 256 bytes: 2N+2 = 514 cycles, 256 writes.
    we0 = we_total;
    apply_stimulus(2'b11, 2'd2, 8'h00, 16'h0000, 16'h00FF, 1'b1, 16'h0, 16'h0, 8'h0, 514, 1'b0);
    check_output("we_cycles", we_total - we0, 32'd256);
    check_output("mem_0000", {24'b0, mem[16'h0000]}, 32'h00);
    check_output("mem_0010", {24'b0, mem[16'h0010]}, 32'h01);
    check_output("mem_001F", {24'b0, mem[16'h001F]}, 32'h01);
    check_output("mem_0020", {24'b0, mem[16'h0020]}, 32'h00);

    // Single-address range at the top of memory.
    apply_stimulus(2'b01, 2'd0, 8'hFF, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0, 16'h0, 8'h0, 2, 1'b0);
    apply_stimulus(2'b10, 2'd0, 8'hFF, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0, 16'h0, 8'h0, 3, 1'b0);
    apply_stimulus(2'b10, 2'd0, 8'h00, 16'hFFFF, 16'hFFFF, 1'b0, 16'h1, 16'hFFFF, 8'hFF, 3, 1'b0);

    // Wrapping range FFFE..0001 with address pattern.
    apply_stimulus(2'b11, 2'd1, 8'h00, 16'hFFFE, 16'h0001, 1'b1, 16'h0, 16'h0, 8'h0, 10, 1'b0);
    check_output("mem_FFFE", {24'b0, mem[16'hFFFE]}, 32'hFE);
    check_output("mem_FFFF", {24'b0, mem[16'hFFFF]}, 32'hFF);
    check_output("mem_0001", {24'b0, mem[16'h0001]}, 32'h01);

    // Checkerboard with one corrupted byte: 0x8005 expects AA, reads 80.
    apply_stimulus(2'b01, 2'd3, 8'h00, 16'h8000, 16'h800F, 1'b1, 16'h0, 16'h0, 8'h0, 17, 1'b0);
    poke_addr = 16'h8005; poke_data = 8'h80; poke_en = 1'b1;
    @(posedge clk); #1;
    poke_en = 1'b0;
    apply_stimulus(2'b10, 2'd3, 8'h00, 16'h8000, 16'h800F, 1'b0, 16'h1, 16'h8005, 8'h80, 18, 1'b0);

    // Abort in the 10th FILL cycle: addresses 0..9 written, no done.
    op = 2'b01; mode = 2'd0; pat_val = 8'h5A; start_addr = 16'h0000; end_addr = 16'h0063;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_output("abort_ram_we", {31'b0, ram_we}, 32'd0);
    check_output("abort_busy", {31'b0, busy}, 32'd0);
    check_output("abort_pass", {31'b0, pass}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_output("abort_mem_0009", {24'b0, mem[16'h0009]}, 32'h5A);
    check_output("abort_mem_000A", {24'b0, mem[16'h000A]}, 32'h00);

    // No-op run after the abort, then a start glitch while busy must not disturb the config.
    apply_stimulus(2'b00, 2'd0, 8'h00, 16'h0000, 16'h0000, 1'b1, 16'h0, 16'h0, 8'h0, 1, 1'b0);
    apply_stimulus(2'b11, 2'd1, 8'h00, 16'h0040, 16'h0047, 1'b1, 16'h0, 16'h0, 8'h0, 18, 1'b1);
    check_output("glitch_mem_0047", {24'b0, mem[16'h0047]}, 32'h47);

    // Asynchronous reset mid-VERIFY.
    op = 2'b10; mode = 2'd1; pat_val = 8'h00; start_addr = 16'h0040; end_addr = 16'h0047;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_output("arst_v_ram_addr", {16'b0, ram_addr}, 32'd0);
    check_output("arst_v_busy", {31'b0, busy}, 32'd0);
    check_output("arst_v_pass", {31'b0, pass}, 32'd0);
    check_output("arst_v_ram_din", {24'b0, ram_din}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Asynchronous reset mid-FILL drops ram_we without a clock edge.
    op = 2'b01; mode = 2'd0; pat_val = 8'h11; start_addr = 16'h0100; end_addr = 16'h01FF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_output("arst_f_ram_we", {31'b0, ram_we}, 32'd0);
    check_output("arst_f_ram_addr", {16'b0, ram_addr}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
